// File: rtl/bru_pkg.sv
// Shared types for the branch resolution unit.
// Optional feature macro: BRU_STATS_EN (stat counters on the top level).
// Struct field widths follow the BRU_* localparams. If the top-level width
// parameters are overridden, these localparams must be changed to match.
package bru_pkg;

  localparam int NUM_FU        = 3;
  localparam int BRU_DATA_W    = 32;
  localparam int BRU_ROB_IDX_W = 5;
  localparam int BRU_PHYS_W    = 6;

  typedef enum logic {
    IDLE,
    REDIRECT
  } bru_state_e;

  typedef struct packed {
    logic [BRU_DATA_W-1:0]    pc;
    logic                     jalr;
    logic [BRU_ROB_IDX_W-1:0] rob_idx;
    logic [BRU_PHYS_W-1:0]    phys_rd;
  } bru_redirect_t;

  typedef struct packed {
    logic [BRU_DATA_W-1:0] pc;
    logic                  mispred;
  } bru_upd_t;

endpackage

// File: rtl/bru_upd_fifo.sv
// Predictor-update FIFO: up to NUM_FU writes and one read per cycle.
// Optional feature macro: BRU_STATS_EN (drop_cnt is consumed by the top only
// when the macro is defined).
// Requests are accepted in FU order while free slots remain. Free slots are
// counted before this cycle's pop, so a pop never makes room for a same-cycle
// push. Requests that do not fit are dropped and counted in drop_cnt.
module bru_upd_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_FU-1:0] push_req,
  input  bru_upd_t          push_data [NUM_FU],
  input  logic              pop_ready,
  output logic              head_valid,
  output bru_upd_t          head,
  output logic [1:0]        drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  occ;
  logic [PTR_W-1:0]  free_slots;
  logic [PTR_W-1:0]  n_push;
  logic              full;
  logic              empty;
  logic              pop;
  logic [NUM_FU-1:0] push_en;
  logic [AW-1:0]     slot [NUM_FU];
  bru_upd_t          mem  [DEPTH];

  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign occ        = wr_ptr - rd_ptr;
  assign free_slots = full ? '0 : (PTR_W'(DEPTH) - occ);
  assign head_valid = !empty;
  assign pop        = head_valid && pop_ready;
  // Gate the head so outputs read zero while empty, including out of reset.
  assign head       = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Assign consecutive slots to accepted requests in FU order; count the rest as drops.
  always_comb begin
    n_push   = '0;
    drop_cnt = '0;
    push_en  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      slot[k] = wr_ptr[AW-1:0] + n_push[AW-1:0];
      if (push_req[k]) begin
        if (n_push < free_slots) begin
          push_en[k] = 1'b1;
          n_push     = n_push + PTR_W'(1);
        end else begin
          drop_cnt = drop_cnt + 2'd1;
        end
      end
    end
  end

  // Pointer update; pointers carry one extra wrap bit.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push;
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage write; data storage needs no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_FU; k++) begin
      if (push_en[k] && !rst_n) mem[slot[k]] <= push_data[k];
    end
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: picks the oldest mispredicted branch among the FUs,
// holds the redirect to fetch until it is accepted, pulses a squash, and
// queues predictor updates.
// Optional feature macro: BRU_STATS_EN (adds stat_mispred_cnt_o / stat_drop_cnt_o).
// rst_n is a synchronous ACTIVE-HIGH reset; the name is kept for compatibility.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no redirect outstanding
// REDIRECT | redirect held on the fetch interface until it is accepted
module branch_resolution_unit
  import bru_pkg::*;
#(
  parameter int DATA_WIDTH = BRU_DATA_W,
  parameter int ROB_IDX_W  = BRU_ROB_IDX_W,
  parameter int PHYS_W     = BRU_PHYS_W,
  parameter int UPD_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ROB_IDX_W-1:0]  rob_head_i,
  input  logic [NUM_FU-1:0]     fu_valid_i,
  input  logic [NUM_FU-1:0]     fu_mispred_i,
  input  logic [NUM_FU-1:0]     fu_is_jalr_i,
  input  logic [DATA_WIDTH-1:0] fu_correct_pc_i [NUM_FU],
  input  logic [ROB_IDX_W-1:0]  fu_rob_idx_i    [NUM_FU],
  input  logic [PHYS_W-1:0]     fu_phys_rd_i    [NUM_FU],
  input  logic [NUM_FU-1:0]     fu_upd_i,
  input  logic [DATA_WIDTH-1:0] fu_upd_pc_i     [NUM_FU],
  output logic                  redirect_valid_o,
  input  logic                  redirect_ready_i,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  redirect_jalr_o,
  output logic                  flush_o,
  output logic [ROB_IDX_W-1:0]  flush_rob_idx_o,
  output logic [PHYS_W-1:0]     flush_phys_rd_o,
  output logic                  upd_valid_o,
  input  logic                  upd_ready_i,
  output logic [DATA_WIDTH-1:0] upd_pc_o,
  output logic                  upd_mispred_o
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]           stat_mispred_cnt_o,
  output logic [15:0]           stat_drop_cnt_o
`endif
);

  bru_state_e           state;
  bru_redirect_t        held;
  bru_redirect_t        best;
  logic                 found;
  logic                 take_new;
  logic [ROB_IDX_W-1:0] best_age;
  logic [ROB_IDX_W-1:0] held_age;
  logic [ROB_IDX_W-1:0] age [NUM_FU];
  bru_upd_t             upd_data [NUM_FU];
  bru_upd_t             upd_head;
  logic [1:0]           drop_cnt;

  // Oldest candidate by ROB age; strict compare lets the lower FU index win ties.
  always_comb begin
    found    = 1'b0;
    best_age = '0;
    best     = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      age[k] = fu_rob_idx_i[k] - rob_head_i;
      if (fu_valid_i[k] && fu_mispred_i[k] && (!found || age[k] < best_age)) begin
        found        = 1'b1;
        best_age     = age[k];
        best.pc      = fu_correct_pc_i[k];
        best.jalr    = fu_is_jalr_i[k];
        best.rob_idx = fu_rob_idx_i[k];
        best.phys_rd = fu_phys_rd_i[k];
      end
    end
  end

  // Held age is re-measured against the current head so both ages share a reference.
  assign held_age = held.rob_idx - rob_head_i;
  assign take_new = found && ((state == IDLE) || (best_age < held_age));

  // Redirect FSM; a strictly older candidate replaces the held payload even when fetch accepts.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state            <= IDLE;
      held             <= '0;
      redirect_valid_o <= 1'b0;
      flush_o          <= 1'b0;
    end else begin
      flush_o <= take_new;
      case (state)
        IDLE: begin
          if (take_new) begin
            held             <= best;
            state            <= REDIRECT;
            redirect_valid_o <= 1'b1;
          end
        end
        REDIRECT: begin
          if (take_new) begin
            held <= best;
          end else if (redirect_ready_i) begin
            state            <= IDLE;
            redirect_valid_o <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          redirect_valid_o <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_pc_o   = held.pc;
  assign redirect_jalr_o = held.jalr;
  assign flush_rob_idx_o = held.rob_idx;
  assign flush_phys_rd_o = held.phys_rd;

  // Pack per-FU predictor updates for the FIFO.
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      upd_data[k].pc      = fu_upd_pc_i[k];
      upd_data[k].mispred = fu_mispred_i[k];
    end
  end

  bru_upd_fifo #(
    .DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_req   (fu_upd_i),
    .push_data  (upd_data),
    .pop_ready  (upd_ready_i),
    .head_valid (upd_valid_o),
    .head       (upd_head),
    .drop_cnt   (drop_cnt)
  );

  assign upd_pc_o      = upd_head.pc;
  assign upd_mispred_o = upd_head.mispred;

`ifdef BRU_STATS_EN
  // Saturating statistics: latched mispredicts (incl. replaces) and dropped updates.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stat_mispred_cnt_o <= '0;
      stat_drop_cnt_o    <= '0;
    end else begin
      if (take_new && (stat_mispred_cnt_o != 32'hFFFF_FFFF))
        stat_mispred_cnt_o <= stat_mispred_cnt_o + 32'd1;
      if (stat_drop_cnt_o > (16'hFFFF - 16'(drop_cnt)))
        stat_drop_cnt_o <= 16'hFFFF;
      else
        stat_drop_cnt_o <= stat_drop_cnt_o + 16'(drop_cnt);
    end
  end
`else
  logic unused_drop;
  assign unused_drop = ^drop_cnt;
`endif

endmodule
